snitch_tcdm_event_counter: RTL and testbench
============================================

// Module: snitch_tcdm_event_counter
// PURPOSE
// - Upstream event source for the cluster performance-counter peripheral.
// - Observes the request handshakes of every TCDM interconnect port.
// - Each cycle, reduces them to two counts:
//   - inc_accessed: number of requests granted this cycle.
//   - inc_congested: number of requests stalled this cycle.
// - Two-stage pipelined popcount, so wide crossbars meet timing.
// - Drives the peripheral's tcdm_events input, which the peripheral adds to its selected counters.
// PARAMETERS
// - NrPorts       default 32  number of observed TCDM request ports (>=1)
// - GroupSize     default 8   ports per stage-1 partial popcount (>=1)
// - StallCntWidth default 16  width of the per-port stall-streak counters (opt. feature)
// - tcdm_events_t default logic  struct {inc_accessed, inc_congested}; each field IncWidth bits
// - IncWidth (localparam) = $clog2(NrPorts+1)
// PORTS
// - clk_i           in   1            cluster clock
// - rst_ni          in   1            synchronous active-low reset, sampled on rising clk_i
// - en_i            in   1            1 = count; 0 = stage 1 captures zeros
// - req_valid_i     in   NrPorts      TCDM request valid, per port
// - req_ready_i     in   NrPorts      TCDM request ready, per port
// - clear_i         in   1            one-cycle pulse: clears max-stall statistics
// - tcdm_events_o   out  tcdm_events_t  registered per-cycle event increments
// - max_stall_o     out  StallCntWidth  longest stall streak seen on any port (opt. feature)
// BEHAVIOUR
// - Port classification, per cycle:
//   - acc[p] = valid & ready.
//   - cong[p] = valid & ~ready.
//   - ready without valid counts as nothing.
// - Stage 1 (registered):
//   - NG = ceil(NrPorts/GroupSize) groups; each stores popcount(acc) and popcount(cong) of its ports.
//   - A trailing partial group is zero-padded.
//   - Partial width = $clog2(GroupSize+1).
//   - en_i=0 captures zero into all stage-1 registers.
// - Stage 2 (registered):
//   - tcdm_events_o.inc_accessed / .inc_congested = sum of the NG partials, zero-extended to IncWidth.
//   - Never overflows: the maximum value is NrPorts.
// - Latency:
//   - A handshake in cycle N appears on tcdm_events_o in cycle N+2.
//   - Throughput is one sample per cycle, with no gaps or back-pressure.
// - en_i timing:
//   - Samples taken before en_i fell still drain through stage 2.
//   - Outputs read zero from the second cycle after en_i falls.
// - Reset: all pipeline registers are 0, so tcdm_events_o = '0 in the cycle after reset is sampled low.
// - Reset mid-operation: in-flight samples are discarded, never emitted.
// - Invariant: inc_accessed + inc_congested <= NrPorts in every cycle.
// CONFIGURATION
// - Macro SNITCH_TCDM_EVENTS_MAX_STALL_EN.
// - Defined:
//   - Per port: streak[p] increments when cong[p]=1 and saturates at 2^StallCntWidth-1.
//   - streak[p] clears to 0 when valid=0 or acc[p]=1.
//   - The register max_stall_q updates once per cycle: max_stall_q <= max(max_stall_q, max over p of streak_q[p]).
//   - Because it reads registered streaks, max_stall_o lags a streak by 1 cycle.
//   - Saturates; never wraps.
//   - clear_i=1 sets max_stall_q to 0 AND all streaks to 0; clear wins over a simultaneous update or increment.
//   - en_i does not gate the streak counters.
//   - Reset: max_stall_o = 0 and all streaks = 0.
// - Undefined:
//   - No streak or max registers are built.
//   - max_stall_o is tied to '0.
//   - clear_i is ignored.
// TESTING
// - Reset, then NrPorts=32, GroupSize=8, en_i=1, idle bus -> tcdm_events_o = {0,0} every cycle.
// - Cycle 10: valid=32'hFFFF_FFFF, ready=32'h0000_FFFF, for 1 cycle
//   -> cycle 12: {inc_accessed=16, inc_congested=16}; cycle 13: {0,0}.
// - NrPorts=12, GroupSize=8, valid=ready=12'hFFF held
//   -> steady {12,0}, correct across the zero-padded partial group.
// - Drop en_i for 3 cycles with all ports granted
//   -> exactly two more {32,0} samples, then zeros, then resume 2 cycles after en_i rises.
// - MAX_STALL_EN, StallCntWidth=4: port 5 stalled 20 cycles, then granted
//   -> max_stall_o saturates at 15; a clear_i pulse -> 0 the next cycle.
// - Assert rst_ni low while traffic is in the pipe
//   -> tcdm_events_o = '0 the cycle after reset is sampled, and no stale sample ever appears after release.

Source files
------------

// File: rtl/snitch_tcdm_event_counter.sv
// Pipelined TCDM handshake popcount for the cluster performance counters.
// Optional per-port stall-streak statistics: define SNITCH_TCDM_EVENTS_MAX_STALL_EN.
module snitch_tcdm_event_counter #(
    parameter int unsigned NrPorts       = 32,
    parameter int unsigned GroupSize     = 8,
    parameter int unsigned StallCntWidth = 16,
    // Packed {inc_accessed, inc_congested}, each $clog2(NrPorts+1) bits, inc_accessed in the MSBs.
    parameter type         tcdm_events_t = logic [2*$clog2(NrPorts+1)-1:0]
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic [NrPorts-1:0]       req_valid_i,
    input  logic [NrPorts-1:0]       req_ready_i,
    input  logic                     clear_i,
    output tcdm_events_t             tcdm_events_o,
    output logic [StallCntWidth-1:0] max_stall_o
);

    localparam int unsigned IncWidth    = $clog2(NrPorts + 1);
    localparam int unsigned NumGroups   = (NrPorts + GroupSize - 1) / GroupSize;
    localparam int unsigned PaddedPorts = NumGroups * GroupSize;
    localparam int unsigned PartWidth   = $clog2(GroupSize + 1);
    localparam int unsigned SumWidth    = (PartWidth > IncWidth) ? PartWidth : IncWidth;

    logic [PaddedPorts-1:0] w_acc;
    logic [PaddedPorts-1:0] w_cong;
    logic [PartWidth-1:0]   w_acc_part  [NumGroups];
    logic [PartWidth-1:0]   w_cong_part [NumGroups];
    logic [PartWidth-1:0]   r_acc_part  [NumGroups];
    logic [PartWidth-1:0]   r_cong_part [NumGroups];
    logic [SumWidth-1:0]    w_acc_sum;
    logic [SumWidth-1:0]    w_cong_sum;
    logic [IncWidth-1:0]    r_inc_accessed;
    logic [IncWidth-1:0]    r_inc_congested;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_acc                = '0;
        w_cong               = '0;
        w_acc[NrPorts-1:0]   = req_valid_i & req_ready_i;
        w_cong[NrPorts-1:0]  = req_valid_i & ~req_ready_i;
        for (int g = 0; g < NumGroups; g++) begin
            w_acc_part[g]  = '0;
            w_cong_part[g] = '0;
            for (int b = 0; b < GroupSize; b++) begin
                w_acc_part[g]  = w_acc_part[g]  + PartWidth'(w_acc[g*GroupSize + b]);
                w_cong_part[g] = w_cong_part[g] + PartWidth'(w_cong[g*GroupSize + b]);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so stages advance in lockstep.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || !en_i) begin
            for (int g = 0; g < NumGroups; g++) begin
                r_acc_part[g]  <= '0;
                r_cong_part[g] <= '0;
            end
        end else begin
            for (int g = 0; g < NumGroups; g++) begin
                r_acc_part[g]  <= w_acc_part[g];
                r_cong_part[g] <= w_cong_part[g];
            end
        end
    end

    always_comb begin
        w_acc_sum  = '0;
        w_cong_sum = '0;
        for (int g = 0; g < NumGroups; g++) begin
            w_acc_sum  = w_acc_sum  + SumWidth'(r_acc_part[g]);
            w_cong_sum = w_cong_sum + SumWidth'(r_cong_part[g]);
        end
    end

    // Sums are bounded by NrPorts, so narrowing to IncWidth never drops a set bit.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_inc_accessed  <= '0;
            r_inc_congested <= '0;
        end else begin
            r_inc_accessed  <= IncWidth'(w_acc_sum);
            r_inc_congested <= IncWidth'(w_cong_sum);
        end
    end

    assign tcdm_events_o = {r_inc_accessed, r_inc_congested};

`ifdef SNITCH_TCDM_EVENTS_MAX_STALL_EN
    logic [StallCntWidth-1:0] r_streak [NrPorts];
    logic [StallCntWidth-1:0] r_max_stall;
    logic [StallCntWidth-1:0] w_streak_max;

    always_comb begin
        w_streak_max = '0;
        for (int p = 0; p < NrPorts; p++) begin
            if (r_streak[p] > w_streak_max) w_streak_max = r_streak[p];
        end
    end

    // NOTE: the streak array is a bank of flops, not a RAM, so it is reset like any other register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            for (int p = 0; p < NrPorts; p++) r_streak[p] <= '0;
            r_max_stall <= '0;
        end else begin
            for (int p = 0; p < NrPorts; p++) begin
                if (!w_cong[p])
                    r_streak[p] <= '0;
                else if (r_streak[p] != '1)
                    r_streak[p] <= r_streak[p] + StallCntWidth'(1);
            end
            if (w_streak_max > r_max_stall) r_max_stall <= w_streak_max;
        end
    end

    assign max_stall_o = r_max_stall;
`else
    logic w_unused_clear;
    assign w_unused_clear = clear_i;
    assign max_stall_o    = '0;
`endif

endmodule

// File: tb/tb_snitch_tcdm_event_counter.sv
// Scoreboard bench for snitch_tcdm_event_counter: a 32-port and a 12-port instance share stimulus.
module tb_snitch_tcdm_event_counter;

    typedef struct packed {
        logic [5:0] inc_accessed;
        logic [5:0] inc_congested;
    } ev32_t;

    typedef struct packed {
        logic [3:0] inc_accessed;
        logic [3:0] inc_congested;
    } ev12_t;

`ifdef SNITCH_TCDM_EVENTS_MAX_STALL_EN
    localparam bit MaxEn = 1'b1;
`else
    localparam bit MaxEn = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clear;
    logic [31:0] valid;
    logic [31:0] ready;
    ev32_t       events32;
    ev12_t       events12;
    logic [3:0]  max_stall32;
    logic [15:0] max_stall12;

    ev32_t q32[$];
    ev12_t q12[$];
    int    errors = 0;
    int    checks = 0;

    snitch_tcdm_event_counter #(
        .NrPorts(32), .GroupSize(8), .StallCntWidth(4), .tcdm_events_t(ev32_t)
    ) dut32 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en),
        .req_valid_i(valid), .req_ready_i(ready), .clear_i(clear),
        .tcdm_events_o(events32), .max_stall_o(max_stall32)
    );

    snitch_tcdm_event_counter #(
        .NrPorts(12), .GroupSize(8), .StallCntWidth(16), .tcdm_events_t(ev12_t)
    ) dut12 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en),
        .req_valid_i(valid[11:0]), .req_ready_i(ready[11:0]), .clear_i(clear),
        .tcdm_events_o(events12), .max_stall_o(max_stall12)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Called at a negedge: check what the DUTs show now, then drive the next cycle's inputs.
    task automatic step(input logic [31:0] v, input logic [31:0] r,
                        input logic e, input logic c);
        ev32_t exp32;
        ev12_t exp12;
        ev32_t new32;
        ev12_t new12;
        logic [31:0] acc;
        logic [31:0] cong;
        exp32 = q32.pop_front();
        exp12 = q12.pop_front();
        checks++;
        if (events32 !== exp32) begin
            errors++;
            $display("FAIL events32 at %0t: got acc=%0d cong=%0d, want acc=%0d cong=%0d", $time,
                     events32.inc_accessed, events32.inc_congested,
                     exp32.inc_accessed, exp32.inc_congested);
        end
        checks++;
        if (events12 !== exp12) begin
            errors++;
            $display("FAIL events12 at %0t: got acc=%0d cong=%0d, want acc=%0d cong=%0d", $time,
                     events12.inc_accessed, events12.inc_congested,
                     exp12.inc_accessed, exp12.inc_congested);
        end
        valid = v;
        ready = r;
        en    = e;
        clear = c;
        acc   = v & r;
        cong  = v & ~r;
        new32 = '0;
        new12 = '0;
        if (e) begin
            new32.inc_accessed  = 6'($countones(acc));
            new32.inc_congested = 6'($countones(cong));
            new12.inc_accessed  = 4'($countones(acc[11:0]));
            new12.inc_congested = 4'($countones(cong[11:0]));
        end
        q32.push_back(new32);
        q12.push_back(new12);
        @(negedge clk);
    endtask

    task automatic check_max(input string name, input logic [3:0] want);
        checks++;
        if (max_stall32 !== want) begin
            errors++;
            $display("FAIL %s: max_stall got %0d, want %0d", name, max_stall32, want);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (events32 !== '0 || events12 !== '0) begin
            errors++;
            $display("FAIL reset_events: got %h / %h, want 0 / 0", events32, events12);
        end
        checks++;
        if (max_stall32 !== '0 || max_stall12 !== '0) begin
            errors++;
            $display("FAIL reset_max_stall: got %0d / %0d, want 0 / 0", max_stall32, max_stall12);
        end
        rst_n = 1'b1;
        q32.delete();
        q12.delete();
        repeat (2) begin
            q32.push_back('0);
            q12.push_back('0);
        end
    endtask

    task automatic test_single_pulse();
        repeat (10) step('0, '0, 1'b1, 1'b0);
        step(32'hFFFF_FFFF, 32'h0000_FFFF, 1'b1, 1'b0);
        repeat (4) step('0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_partial_group();
        repeat (6) step(32'h0000_0FFF, 32'h0000_0FFF, 1'b1, 1'b0);
        repeat (3) step(32'h0000_0F0F, 32'h0000_0FF0, 1'b1, 1'b0);
    endtask

    task automatic test_enable();
        repeat (4) step('1, '1, 1'b1, 1'b0);
        repeat (3) step('1, '1, 1'b0, 1'b0);
        repeat (4) step('1, '1, 1'b1, 1'b0);
        repeat (3) step('0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        repeat (30) step($urandom, $urandom, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            logic [31:0] mask;
            mask = 32'h1 << (i * 4);
            step('1, mask - 32'h1, 1'b1, 1'b0);
        end
        step(32'h8000_0001, 32'h0000_0001, 1'b1, 1'b0);
        step(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        repeat (2) step('0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_max_stall();
        logic [31:0] p5;
        p5 = 32'h1 << 5;
        step('0, '0, 1'b1, 1'b1);
        check_max("max_after_clear", 4'd0);
        repeat (5) step(p5, '0, 1'b1, 1'b0);
        check_max("max_lags_streak", MaxEn ? 4'd4 : 4'd0);
        repeat (15) step(p5, '0, 1'b1, 1'b0);
        check_max("max_saturates", MaxEn ? 4'd15 : 4'd0);
        step(p5, p5, 1'b1, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        check_max("max_holds_after_grant", MaxEn ? 4'd15 : 4'd0);
        repeat (3) step(p5, '0, 1'b1, 1'b0);
        step(p5, '0, 1'b1, 1'b1);
        check_max("clear_wins", 4'd0);
        step(p5, '0, 1'b1, 1'b0);
        check_max("streak_cleared_too", 4'd0);
        step(p5, '0, 1'b1, 1'b0);
        check_max("streak_restarts", MaxEn ? 4'd1 : 4'd0);
        step('0, '0, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid();
        repeat (3) step('1, 32'h00FF_00FF, 1'b1, 1'b0);
        test_reset();
        repeat (5) step('0, '0, 1'b1, 1'b0);
        check_max("max_after_mid_reset", 4'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        clear = 1'b0;
        valid = '1;
        ready = '0;
        @(negedge clk);
        test_reset();
        test_single_pulse();
        test_partial_group();
        test_enable();
        test_random();
        test_back_to_back();
        test_max_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
